alu_exec: RTL and testbench

Registered execute stage of the 16-bit CPU, directly downstream of the ALU control decoder: it consumes the 3-bit ALU code plus two operands and produces a registered result and zero flag for writeback, store and load address generation, and beq.
- Single-cycle ops complete one clock after acceptance.
- Left shift runs bit-serially, one position per clock.
- Valid/ready handshakes on both sides let the pipeline stall around a multi-cycle shift or a blocked consumer.

---
 rtl/alu_exec.sv | 130 +++++++++++++
 tb/tb_alu_exec.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Registered execute stage: single-cycle ALU ops plus a bit-serial left shift,
// with valid/ready handshakes on both the operation input and the result output.
module alu_exec #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpLsl = 3'b010;
    localparam logic [2:0] OpSlt = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpNot = 3'b110;
    localparam logic [2:0] OpXor = 3'b111;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   op_res;
    logic [WIDTH-1:0]   acc_shl;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;

    assign shamt   = b[SHAMT_W-1:0];
    assign acc_shl = acc_q << 1;

    // Combinational result for every op that finishes in one cycle (lsl by 0 included).
    always_comb begin
        op_res = '0;
        unique case (alu_code)
            OpAdd: op_res = a + b;
            OpSub: op_res = a - b;
            OpLsl: op_res = a;
            OpSlt: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpAnd: op_res = a & b;
            OpOr:  op_res = a | b;
            OpNot: op_res = ~a;
            OpXor: op_res = a ^ b;
            default: op_res = '0;
        endcase
    end

    assign in_ready = (state_q == StIdle) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if ((alu_code == OpLsl) && (shamt != '0)) begin
                        acc_d   = a;
                        cnt_d   = shamt;
                        state_d = StShift;
                    end else begin
                        // Overrides the clear above: back-to-back results without a bubble.
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            StShift: begin
                acc_d = acc_shl;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = acc_shl;
                    zero_d   = (acc_shl == '0);
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: expected results are queued at accept and
// checked when the stage presents them.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_code = 3'b000;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        zero;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb[$];

    alu_exec #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_code(alu_code), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [2:0] c, input logic [15:0] x,
                                          input logic [15:0] y);
        case (c)
            3'b000: return x + y;
            3'b001: return x - y;
            3'b010: return x << y[3:0];
            3'b011: return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
            3'b100: return x & y;
            3'b101: return x | y;
            3'b110: return ~x;
            default: return x ^ y;
        endcase
    endfunction

    // Present an op, wait for acceptance, queue its expected result.
    task automatic issue(input string name, input logic [2:0] c, input logic [15:0] x,
                         input logic [15:0] y);
        bit got = 0;
        in_valid = 1'b1;
        alu_code = c;
        a = x;
        b = y;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                got = 1;
                break;
            end
        end
        in_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s accept: in_ready never high, required accept within 40 cycles", name);
        end else begin
            sb.push_back(model(c, x, y));
        end
    endtask

    // Wait for out_valid (out_ready high), compare against scoreboard and latency.
    task automatic collect(input string name, input int lat);
        int waits = 0;
        logic [15:0] e;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                waits = i;
                break;
            end
        end
        total++;
        if (waits == 0) begin
            bad++;
            $display("FAIL %s out_valid: never rose, required within 40 cycles", name);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: result %h with nothing expected", name, result);
        end else begin
            e = sb.pop_front();
            if (result !== e) begin
                bad++;
                $display("FAIL %s result: got %h, required %h", name, result, e);
            end
            total++;
            if (zero !== (e == 16'h0)) begin
                bad++;
                $display("FAIL %s zero: got %b, required %b", name, zero, (e == 16'h0));
            end
            total++;
            if (waits != lat) begin
                bad++;
                $display("FAIL %s latency: got %0d, required %0d", name, waits, lat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, busy, zero, result} !== 19'h0) begin
            bad++;
            $display("FAIL reset outputs: got v=%b busy=%b z=%b r=%h, required all 0",
                     out_valid, busy, zero, result);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_arith();
        issue("add", 3'b000, 16'h7FFF, 16'h0001);  collect("add", 1);
        issue("sub_wrap", 3'b001, 16'h0000, 16'h0001);  collect("sub_wrap", 1);
        issue("sub_eq", 3'b001, 16'h1234, 16'h1234);  collect("sub_eq", 1);
        issue("slt_neg", 3'b011, 16'hFFFF, 16'h0001);  collect("slt_neg", 1);
        issue("slt_pos", 3'b011, 16'h0001, 16'hFFFF);  collect("slt_pos", 1);
        issue("and", 3'b100, 16'hF0F0, 16'h3C3C);  collect("and", 1);
        issue("or", 3'b101, 16'hF000, 16'h000F);  collect("or", 1);
        issue("not", 3'b110, 16'h00FF, 16'hAAAA);  collect("not", 1);
        issue("xor", 3'b111, 16'hAAAA, 16'hAAAA);  collect("xor", 1);
    endtask

    task automatic test_lsl();
        issue("lsl5", 3'b010, 16'h0003, 16'h0005);
        // Inputs changed after accept must not affect the shift.
        a = 16'hFFFF;
        b = 16'h0001;
        alu_code = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL lsl5 cycle %0d: got busy=%b rdy=%b v=%b, required 1 0 0",
                         i, busy, in_ready, out_valid);
            end
        end
        collect("lsl5", 1);
        issue("lsl0", 3'b010, 16'hBEEF, 16'h0000);  collect("lsl0", 1);
        issue("lsl16", 3'b010, 16'h1357, 16'h0010);  collect("lsl16", 1);
        issue("lsl15", 3'b010, 16'h0001, 16'h000F);  collect("lsl15", 16);
        issue("lsl_out", 3'b010, 16'h8001, 16'h0001);  collect("lsl_out", 2);
        issue("lsl_zero", 3'b010, 16'h0100, 16'h0008);  collect("lsl_zero", 9);
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        out_ready = 1'b0;
        issue("bp_and", 3'b100, 16'hF0F0, 16'h3C3C);
        in_valid = 1'b1;
        alu_code = 3'b101;
        a = 16'h0001;
        b = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== 16'h3030 || zero !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp hold %0d: got v=%b r=%h z=%b rdy=%b, required 1 3030 0 0",
                         i, out_valid, result, zero, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        total++;
        if (out_valid !== 1'b1 || result !== e || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp release: got v=%b r=%h rdy=%b, required 1 %h 1",
                     out_valid, result, in_ready, e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(3'b101, 16'h0001, 16'h0002));
        collect("bp_next", 1);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  codes[4] = '{3'b000, 3'b111, 3'b001, 3'b110};
        logic [15:0] xs[4]    = '{16'h1111, 16'h5A5A, 16'h0005, 16'h0F0F};
        logic [15:0] ys[4]    = '{16'h2222, 16'hFFFF, 16'h0007, 16'h0000};
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            alu_code = codes[i];
            a = xs[i];
            b = ys[i];
            @(negedge clk);
            if (i > 0) begin
                e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                total++;
                if (out_valid !== 1'b1 || result !== e) begin
                    bad++;
                    $display("FAIL b2b %0d: got v=%b r=%h, required 1 %h", i - 1, out_valid, result, e);
                end
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b ready %0d: got %b, required 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            sb.push_back(model(codes[i], xs[i], ys[i]));
        end
        in_valid = 1'b0;
        collect("b2b_last", 1);
    endtask

    task automatic test_reset_mid_shift();
        issue("rst_lsl", 3'b010, 16'h0001, 16'h000A);
        sb.delete();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid: got v=%b busy=%b r=%h, required 0 0 0000", out_valid, busy, result);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid in_ready: got %b, required 1", in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid stale %0d: got v=%b busy=%b r=%h, required 0 0",
                         i, out_valid, busy, result);
            end
        end
        issue("post_rst", 3'b000, 16'h0002, 16'h0003);
        collect("post_rst", 1);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_lsl();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
